id_lifecycle_tracker: RTL and testbench

Parametrised successor to the core's fixed ID manager. It allocates instruction IDs from a ring of NUM_IDS entries and tracks each ID through alloc, fetch, decode, issue and completion. It accepts N_COMPLETE independent completion ports and frees unissued IDs on a fetch flush. An INIT sweep FSM produces a clear stream for external per-ID metadata RAMs.

---
 rtl/id_lifecycle_if.sv | 43 ++++
 rtl/id_lifecycle_tracker.sv | 160 ++++++++++++++++
 tb/tb_id_lifecycle_tracker.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/id_lifecycle_if.sv
// Handshake bundle between the instruction pipeline and the ID lifecycle tracker.
// The master side is the pipeline. The slave side is the tracker.
interface id_lifecycle_if #(
    parameter int NUM_IDS    = 8,
    parameter int N_COMPLETE = 3
);
    localparam int IDW = $clog2(NUM_IDS);
    localparam int CW  = $clog2(N_COMPLETE + 1);

    logic                      reinit;
    logic                      init_done;
    logic                      clear_valid;
    logic [IDW-1:0]            clear_id;
    logic                      alloc_available;
    logic [IDW-1:0]            alloc_id;
    logic                      alloc_req;
    logic [IDW-1:0]            fetch_id;
    logic                      fetch_complete;
    logic                      decode_valid;
    logic [IDW-1:0]            decode_id;
    logic                      decode_advance;
    logic                      issue_valid;
    logic [IDW-1:0]            issue_id;
    logic                      flush;
    logic [N_COMPLETE-1:0]     complete_valid;
    logic [N_COMPLETE*IDW-1:0] complete_id;
    logic [IDW:0]              inflight_count;
    logic [CW-1:0]             retire_inc;

    modport master (
        output reinit, alloc_req, fetch_complete, decode_advance, issue_valid,
               issue_id, flush, complete_valid, complete_id,
        input  init_done, clear_valid, clear_id, alloc_available, alloc_id,
               fetch_id, decode_valid, decode_id, inflight_count, retire_inc
    );

    modport slave (
        input  reinit, alloc_req, fetch_complete, decode_advance, issue_valid,
               issue_id, flush, complete_valid, complete_id,
        output init_done, clear_valid, clear_id, alloc_available, alloc_id,
               fetch_id, decode_valid, decode_id, inflight_count, retire_inc
    );
endinterface

// File: rtl/id_lifecycle_tracker.sv
// Ring allocator for instruction IDs: tracks alloc/fetch/decode/issue/complete per ID,
// frees unissued IDs on flush, and sweeps a clear stream for metadata RAMs in INIT.
module id_lifecycle_tracker #(
    parameter int NUM_IDS    = 8,
    parameter int N_COMPLETE = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    id_lifecycle_if.slave bus
);
    localparam int IDW = $clog2(NUM_IDS);
    localparam int CW  = $clog2(N_COMPLETE + 1);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [IDW-1:0]        idx_q, idx_d;
    logic [IDW-1:0]        alloc_q, alloc_d, fetch_q, fetch_d, dec_q, dec_d;
    logic [IDW:0]          fcnt_q, fcnt_d;
    logic [NUM_IDS-1:0]    busy_q, busy_d, iss_q, iss_d;
    logic                  avail_q, avail_d;
    logic [IDW:0]          inflight_q, inflight_d;
    logic [CW-1:0]         retire_q, retire_d;
    logic [N_COMPLETE-1:0] acc;
    logic [IDW-1:0]        cid [N_COMPLETE];
    logic                  run, live, dec_ok;
    logic                  err_alloc, err_dec, err_cmp, err_dup;

    function automatic logic [IDW:0] popcount(input logic [NUM_IDS-1:0] v);
        logic [IDW:0] c;
        c = '0;
        for (int i = 0; i < NUM_IDS; i++) c = c + (IDW+1)'(v[i]);
        return c;
    endfunction

    always_comb begin
        run  = (state_q == ST_RUN);
        live = run & ~bus.reinit;
        for (int k = 0; k < N_COMPLETE; k++) begin
            cid[k] = bus.complete_id[k*IDW +: IDW];
            acc[k] = live & bus.complete_valid[k] & busy_q[cid[k]] & iss_q[cid[k]];
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        alloc_d  = alloc_q;
        fetch_d  = fetch_q;
        dec_d    = dec_q;
        fcnt_d   = fcnt_q;
        busy_d   = busy_q;
        iss_d    = iss_q;
        retire_d = '0;
        dec_ok   = 1'b0;
        if (!run) begin
            idx_d = idx_q + IDW'(1);
            if (idx_q == IDW'(NUM_IDS - 1)) state_d = ST_RUN;
        end else if (bus.reinit) begin
            state_d = ST_INIT;
            idx_d   = '0;
            alloc_d = '0;
            fetch_d = '0;
            dec_d   = '0;
            fcnt_d  = '0;
            busy_d  = '0;
            iss_d   = '0;
        end else begin
            if (bus.flush) begin
                // An ID issued in the flush cycle is already past the flush point.
                for (int i = 0; i < NUM_IDS; i++)
                    if (busy_q[i] && !iss_q[i] && !(bus.issue_valid && bus.issue_id == IDW'(i)))
                        busy_d[i] = 1'b0;
                alloc_d = dec_q;
                fetch_d = dec_q;
                fcnt_d  = '0;
            end else begin
                if (bus.alloc_req && avail_q) begin
                    busy_d[alloc_q] = 1'b1;
                    iss_d[alloc_q]  = 1'b0;
                    alloc_d         = alloc_q + IDW'(1);
                end
                dec_ok = bus.decode_advance && (fcnt_q != '0);
                if (bus.fetch_complete) fetch_d = fetch_q + IDW'(1);
                if (dec_ok) dec_d = dec_q + IDW'(1);
                if (bus.fetch_complete && !dec_ok) fcnt_d = fcnt_q + (IDW+1)'(1);
                else if (!bus.fetch_complete && dec_ok) fcnt_d = fcnt_q - (IDW+1)'(1);
            end
            if (bus.issue_valid) iss_d[bus.issue_id] = 1'b1;
            for (int k = 0; k < N_COMPLETE; k++) begin
                if (acc[k]) begin
                    busy_d[cid[k]] = 1'b0;
                    iss_d[cid[k]]  = 1'b0;
                    retire_d       = retire_d + CW'(1);
                end
            end
        end
        avail_d    = (state_d == ST_RUN) & ~busy_d[alloc_d];
        inflight_d = popcount(busy_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            idx_q      <= '0;
            alloc_q    <= '0;
            fetch_q    <= '0;
            dec_q      <= '0;
            fcnt_q     <= '0;
            busy_q     <= '0;
            iss_q      <= '0;
            avail_q    <= 1'b0;
            inflight_q <= '0;
            retire_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            alloc_q    <= alloc_d;
            fetch_q    <= fetch_d;
            dec_q      <= dec_d;
            fcnt_q     <= fcnt_d;
            busy_q     <= busy_d;
            iss_q      <= iss_d;
            avail_q    <= avail_d;
            inflight_q <= inflight_d;
            retire_q   <= retire_d;
        end
    end

    assign bus.init_done       = run;
    assign bus.clear_valid     = ~run;
    assign bus.clear_id        = idx_q;
    assign bus.alloc_available = avail_q;
    assign bus.alloc_id        = alloc_q;
    assign bus.fetch_id        = fetch_q;
    assign bus.decode_valid    = (fcnt_q != '0);
    assign bus.decode_id       = dec_q;
    assign bus.inflight_count  = inflight_q;
    assign bus.retire_inc      = retire_q;

    // Protocol misuse flags; flush and reinit legitimately swallow alloc/decode requests.
    always_comb begin
        err_alloc = live & ~bus.flush & bus.alloc_req & ~avail_q;
        err_dec   = live & ~bus.flush & bus.decode_advance & (fcnt_q == '0);
        err_cmp   = 1'b0;
        err_dup   = 1'b0;
        for (int k = 0; k < N_COMPLETE; k++) begin
            if (live && bus.complete_valid[k] && !acc[k]) err_cmp = 1'b1;
            for (int j = 0; j < k; j++)
                if (live && bus.complete_valid[k] && bus.complete_valid[j] && cid[k] == cid[j])
                    err_dup = 1'b1;
        end
    end

    a_alloc: assert property (@(posedge clk) disable iff (!rst_n) !err_alloc);
    a_dec:   assert property (@(posedge clk) disable iff (!rst_n) !err_dec);
    a_cmp:   assert property (@(posedge clk) disable iff (!rst_n) !err_cmp);
    a_dup:   assert property (@(posedge clk) disable iff (!rst_n) !err_dup);
endmodule

// File: tb/tb_id_lifecycle_tracker.sv
// Bench for id_lifecycle_tracker: directed lifecycle scenarios followed by randomized
// legal traffic, all checked against a per-ID status model.
module tb_id_lifecycle_tracker;
    localparam int NUM_IDS    = 8;
    localparam int N_COMPLETE = 3;
    localparam int IDW        = $clog2(NUM_IDS);
    localparam int S_FREE = 0, S_BUSY = 1, S_ISS = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_lifecycle_if #(.NUM_IDS(NUM_IDS), .N_COMPLETE(N_COMPLETE)) bus ();

    id_lifecycle_tracker #(.NUM_IDS(NUM_IDS), .N_COMPLETE(N_COMPLETE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: remaining INIT cycles, per-ID status, ring positions.
    int init_left;
    int st [NUM_IDS];
    int m_alloc, m_fetch, m_dec, m_fc, m_retire;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        init_left = NUM_IDS;
        foreach (st[i]) st[i] = S_FREE;
        m_alloc = 0; m_fetch = 0; m_dec = 0; m_fc = 0; m_retire = 0;
    endtask

    task automatic model_update();
        int done_ids[$];
        int id;
        bit dec_ok;
        m_retire = 0;
        if (init_left > 0) begin
            init_left--;
        end else if (bus.reinit) begin
            model_reset();
        end else begin
            for (int k = 0; k < N_COMPLETE; k++) begin
                id = int'(bus.complete_id[k*IDW +: IDW]);
                if (bus.complete_valid[k] && st[id] == S_ISS) done_ids.push_back(id);
            end
            if (bus.issue_valid) st[bus.issue_id] = S_ISS;
            if (bus.flush) begin
                foreach (st[i]) if (st[i] == S_BUSY) st[i] = S_FREE;
                m_alloc = m_dec; m_fetch = m_dec; m_fc = 0;
            end else begin
                if (bus.alloc_req && st[m_alloc] == S_FREE) begin
                    st[m_alloc] = S_BUSY;
                    m_alloc = (m_alloc + 1) % NUM_IDS;
                end
                dec_ok = bus.decode_advance && m_fc > 0;
                if (bus.fetch_complete) begin m_fetch = (m_fetch + 1) % NUM_IDS; m_fc++; end
                if (dec_ok) begin m_dec = (m_dec + 1) % NUM_IDS; m_fc--; end
            end
            foreach (done_ids[j]) st[done_ids[j]] = S_FREE;
            m_retire = done_ids.size();
        end
    endtask

    task automatic check_all();
        int busy_n = 0;
        bit run = (init_left == 0);
        foreach (st[i]) if (st[i] != S_FREE) busy_n++;
        chk("init_done", bus.init_done, run);
        chk("clear_valid", bus.clear_valid, !run);
        if (!run) chk("clear_id", bus.clear_id, NUM_IDS - init_left);
        chk("alloc_available", bus.alloc_available, run && st[m_alloc] == S_FREE);
        chk("alloc_id", bus.alloc_id, m_alloc);
        chk("fetch_id", bus.fetch_id, m_fetch);
        chk("decode_id", bus.decode_id, m_dec);
        chk("decode_valid", bus.decode_valid, m_fc != 0);
        chk("inflight_count", bus.inflight_count, busy_n);
        chk("retire_inc", bus.retire_inc, m_retire);
    endtask

    task automatic clr_in();
        bus.reinit = 0; bus.alloc_req = 0; bus.fetch_complete = 0; bus.decode_advance = 0;
        bus.issue_valid = 0; bus.issue_id = '0; bus.flush = 0;
        bus.complete_valid = '0; bus.complete_id = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic pulse_n(input int n);
        repeat (n) tick();
        clr_in();
    endtask

    task automatic do_reinit();
        clr_in(); bus.reinit = 1; tick(); clr_in();
        repeat (NUM_IDS) tick();
    endtask

    task automatic issue(input int id);
        clr_in(); bus.issue_valid = 1; bus.issue_id = IDW'(id); tick(); clr_in();
    endtask

    // Alloc 0..4, fetch 0..4, decode 0..1, issue 0.
    task automatic setup_flush_case();
        do_reinit();
        bus.alloc_req = 1;      pulse_n(5);
        bus.fetch_complete = 1; pulse_n(5);
        bus.decode_advance = 1; pulse_n(2);
        issue(0);
    endtask

    task automatic drive_random();
        int busy_c[$];
        int iss_c[$];
        int j;
        logic [N_COMPLETE-1:0]     cv;
        logic [N_COMPLETE*IDW-1:0] cv_id;
        cv = '0; cv_id = '0;
        clr_in();
        if (init_left > 0) begin
            bus.alloc_req = 1'($urandom_range(0, 1));
            bus.fetch_complete = 1'($urandom_range(0, 1));
            bus.decode_advance = 1'($urandom_range(0, 1));
            bus.flush = 1'($urandom_range(0, 1));
            bus.reinit = 1'($urandom_range(0, 1));
            bus.issue_valid = 1'($urandom_range(0, 1));
            bus.issue_id = IDW'($urandom_range(0, NUM_IDS - 1));
            return;
        end
        if ($urandom_range(0, 199) == 0) begin
            bus.reinit = 1;
            bus.alloc_req = 1'($urandom_range(0, 1));
            return;
        end
        bus.flush = ($urandom_range(0, 19) == 0);
        if (st[m_alloc] == S_FREE && $urandom_range(0, 9) < 6) bus.alloc_req = 1;
        if (m_fc < NUM_IDS && $urandom_range(0, 1) == 1) bus.fetch_complete = 1;
        if (m_fc > 0 && $urandom_range(0, 1) == 1) bus.decode_advance = 1;
        foreach (st[i]) begin
            if (st[i] == S_BUSY) busy_c.push_back(i);
            if (st[i] == S_ISS)  iss_c.push_back(i);
        end
        if (busy_c.size() > 0 && $urandom_range(0, 9) < 4) begin
            bus.issue_valid = 1;
            bus.issue_id = IDW'(busy_c[$urandom_range(0, busy_c.size() - 1)]);
        end
        for (int k = 0; k < N_COMPLETE; k++) begin
            if (iss_c.size() > 0 && $urandom_range(0, 1) == 1) begin
                j = $urandom_range(0, iss_c.size() - 1);
                cv[k] = 1'b1;
                cv_id[k*IDW +: IDW] = IDW'(iss_c[j]);
                iss_c.delete(j);
            end
        end
        bus.complete_valid = cv;
        bus.complete_id = cv_id;
    endtask

    initial begin
        clr_in();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        repeat (NUM_IDS) tick();
        chk("plan_first_alloc_id", bus.alloc_id, 0);

        // Fill the ring, then free ID 0 through port 2.
        bus.alloc_req = 1; pulse_n(NUM_IDS);
        chk("plan_full_avail", bus.alloc_available, 0);
        chk("plan_full_inflight", bus.inflight_count, NUM_IDS);
        issue(0);
        bus.complete_valid = 3'b100; bus.complete_id[2*IDW +: IDW] = IDW'(0);
        tick(); clr_in();
        chk("plan_free0_avail", bus.alloc_available, 1);
        chk("plan_free0_retire", bus.retire_inc, 1);

        // Flush frees unissued IDs 1..4 and rewinds to decode_id.
        setup_flush_case();
        bus.flush = 1; tick(); clr_in();
        chk("plan_flush_alloc_id", bus.alloc_id, 2);
        chk("plan_flush_inflight", bus.inflight_count, 1);

        // Flush with ID 1 issued in the same cycle keeps it.
        setup_flush_case();
        bus.flush = 1; bus.issue_valid = 1; bus.issue_id = IDW'(1); tick(); clr_in();
        chk("plan_flush_issue_inflight", bus.inflight_count, 2);

        // Three simultaneous completions.
        do_reinit();
        bus.alloc_req = 1; pulse_n(NUM_IDS);
        issue(3); issue(5); issue(6);
        bus.complete_valid = 3'b111;
        bus.complete_id = {IDW'(6), IDW'(5), IDW'(3)};
        tick(); clr_in();
        chk("plan_retire3", bus.retire_inc, 3);
        chk("plan_retire3_inflight", bus.inflight_count, 5);

        // reinit with 5 busy IDs.
        bus.reinit = 1; tick(); clr_in();
        chk("plan_reinit_inflight", bus.inflight_count, 0);
        chk("plan_reinit_clear", bus.clear_valid, 1);
        repeat (NUM_IDS) tick();
        chk("plan_reinit_done", bus.init_done, 1);

        for (int c = 0; c < 3000; c++) begin
            drive_random();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
